// File: rtl/ad4003_pkg.sv
// ad4003_pkg
// Shared constants, FSM state type and beat-word packing helper for the
// AD4003 frame streamer.
//   N_CH / SAMPLE_W : default channel count and sample width
//   TAG_MSB / CH_LSB: field positions inside a 32-bit beat word
//   stream_state_t  : IDLE / STREAM
//   pack_word()     : {tag, channel index, raw sample} -> 32 bits
package ad4003_pkg;

    localparam int N_CH     = 48;
    localparam int SAMPLE_W = 18;
    localparam int WORD_W   = 32;
    localparam int TAG_MSB  = 31;
    localparam int TAG_W    = 8;
    localparam int CH_LSB   = 18;
    localparam int CH_W     = TAG_MSB - TAG_W + 1 - CH_LSB;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // Word layout: tag[31:24], channel index[23:18], raw sample[17:0].
    // The sample is placed as-is, never sign-extended.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [TAG_W-1:0]  tag,
        input logic [CH_W-1:0]   ch,
        input logic [CH_LSB-1:0] sample
    );
        logic [WORD_W-1:0] word;
        word                     = {WORD_W{1'b0}};
        word[TAG_MSB -: TAG_W]   = tag;
        word[CH_LSB +: CH_W]     = ch;
        word[CH_LSB-1:0]         = sample;
        return word;
    endfunction

endpackage

// File: rtl/ad4003_beat_mux.sv
// ad4003_beat_mux
// Combinational selection of channel pair (2*beat, 2*beat+1) from a frame
// snapshot, packed into one 64-bit beat. The parent registers the result.
//   shadow : N_CH*SAMPLE_W frame snapshot, channel k at [SAMPLE_W*k +: SAMPLE_W]
//   beat   : beat index 0 .. N_CH/2-1
//   tag    : frame tag placed in both words
//   pair   : {word(ch 2b+1), word(ch 2b)}
module ad4003_beat_mux #(
    parameter int N_CH     = ad4003_pkg::N_CH,
    parameter int SAMPLE_W = ad4003_pkg::SAMPLE_W,
    parameter int BEAT_W   = 5
) (
    input  logic [N_CH*SAMPLE_W-1:0] shadow,
    input  logic [BEAT_W-1:0]        beat,
    input  logic [7:0]               tag,
    output logic [63:0]              pair
);
    import ad4003_pkg::*;

    logic [CH_W-1:0]     ch_even_s;
    logic [CH_W-1:0]     ch_odd_s;
    logic [SAMPLE_W-1:0] smp_even_s;
    logic [SAMPLE_W-1:0] smp_odd_s;

    // Pick the channel pair addressed by beat and pack both words.
    always_comb begin
        ch_even_s = CH_W'({beat, 1'b0});
        ch_odd_s  = {ch_even_s[CH_W-1:1], 1'b1};
        // Out-of-range beat indices yield zero samples rather than an
        // undefined part-select.
        if (int'(beat) < N_CH / 2) begin
            smp_even_s = shadow[SAMPLE_W*int'(ch_even_s) +: SAMPLE_W];
            smp_odd_s  = shadow[SAMPLE_W*int'(ch_odd_s)  +: SAMPLE_W];
        end else begin
            smp_even_s = {SAMPLE_W{1'b0}};
            smp_odd_s  = {SAMPLE_W{1'b0}};
        end
        pair = {pack_word(tag, ch_odd_s, smp_odd_s),
                pack_word(tag, ch_even_s, smp_even_s)};
    end

endmodule

// File: rtl/ad4003_frame_streamer.sv
// ad4003_frame_streamer
// Snapshots a complete AD4003 conversion frame (N_CH samples) at the falling
// edge of reader_en_sync and streams it as N_CH/2 tagged 64-bit AXI-Stream
// beats. Frames ending while a snapshot is still streaming are dropped and
// counted. Single clock domain (adc_read_clk), asynchronous active-high rst.
//   enable         : allow capture of new frames
//   reader_en_sync : shift-window strobe, high->low marks frame end
//   adc_data       : parallel samples, channel k at [SAMPLE_W*k +: SAMPLE_W]
//   m_tdata/m_tvalid/m_tready/m_tlast : AXI-Stream master
//   busy           : high while streaming
//   frame_cnt      : captured frames (wraps)
//   overflow_cnt   : dropped frames (saturates)
module ad4003_frame_streamer #(
    parameter int N_CH     = ad4003_pkg::N_CH,
    parameter int SAMPLE_W = ad4003_pkg::SAMPLE_W,
    parameter int CNT_W    = 16
) (
    input  logic                     adc_read_clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     reader_en_sync,
    input  logic [N_CH*SAMPLE_W-1:0] adc_data,
    output logic [63:0]              m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [CNT_W-1:0]         overflow_cnt
);
    import ad4003_pkg::*;

    localparam int                N_BEATS   = N_CH / 2;
    localparam int                BEAT_W    = $clog2(N_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    stream_state_t            state_r;
    logic                     reader_en_d_r;
    logic [N_CH*SAMPLE_W-1:0] shadow_r;
    logic [7:0]               tag_r;
    logic [BEAT_W-1:0]        beat_r;
    logic [63:0]              m_tdata_r;
    logic                     m_tvalid_r;
    logic                     m_tlast_r;
    logic                     busy_r;
    logic [CNT_W-1:0]         frame_cnt_r;
    logic [CNT_W-1:0]         overflow_cnt_r;

    logic                     frame_end_s;
    logic                     hs_s;
    logic                     last_hs_s;
    logic                     capture_s;
    logic                     drop_s;
    logic                     advance_s;
    logic [BEAT_W-1:0]        beat_nxt_s;
    logic [N_CH*SAMPLE_W-1:0] mux_src_s;
    logic [7:0]               mux_tag_s;
    logic [63:0]              pair_s;

    // Frame-end detect, capture/drop decisions and the next beat to present.
    always_comb begin
        frame_end_s = reader_en_d_r & ~reader_en_sync;
        hs_s        = m_tvalid_r & m_tready;
        last_hs_s   = hs_s & (beat_r == LAST_BEAT);
        advance_s   = hs_s & ~last_hs_s;
        capture_s   = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                capture_s = frame_end_s & enable;
            end
            STREAM: begin
                // A frame ending exactly on the last handshake can be taken
                // back-to-back; any other frame end while streaming is lost.
                capture_s = last_hs_s & frame_end_s & enable;
                drop_s    = frame_end_s & ~last_hs_s;
            end
            default: begin
                capture_s = 1'b0;
                drop_s    = 1'b0;
            end
        endcase
        // On capture the first beat is built straight from adc_data so that
        // m_tdata is valid in the same cycle m_tvalid rises.
        if (capture_s) begin
            mux_src_s  = adc_data;
            mux_tag_s  = frame_cnt_r[7:0];
            beat_nxt_s = {BEAT_W{1'b0}};
        end else if (advance_s) begin
            mux_src_s  = shadow_r;
            mux_tag_s  = tag_r;
            beat_nxt_s = beat_r + BEAT_W'(1);
        end else begin
            mux_src_s  = shadow_r;
            mux_tag_s  = tag_r;
            beat_nxt_s = beat_r;
        end
    end

    ad4003_beat_mux #(
        .N_CH     (N_CH),
        .SAMPLE_W (SAMPLE_W),
        .BEAT_W   (BEAT_W)
    ) u_beat_mux (
        .shadow (mux_src_s),
        .beat   (beat_nxt_s),
        .tag    (mux_tag_s),
        .pair   (pair_s)
    );

    // Streaming FSM, snapshot, counters and registered AXIS outputs.
    always_ff @(posedge adc_read_clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            reader_en_d_r  <= 1'b0;
            shadow_r       <= {(N_CH*SAMPLE_W){1'b0}};
            tag_r          <= 8'h00;
            beat_r         <= {BEAT_W{1'b0}};
            m_tdata_r      <= 64'h0;
            m_tvalid_r     <= 1'b0;
            m_tlast_r      <= 1'b0;
            busy_r         <= 1'b0;
            frame_cnt_r    <= {CNT_W{1'b0}};
            overflow_cnt_r <= {CNT_W{1'b0}};
        end else begin
            reader_en_d_r <= reader_en_sync;

            if (drop_s && (overflow_cnt_r != {CNT_W{1'b1}})) begin
                overflow_cnt_r <= overflow_cnt_r + CNT_W'(1);
            end

            if (capture_s) begin
                shadow_r    <= adc_data;
                tag_r       <= frame_cnt_r[7:0];
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end

            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        state_r    <= STREAM;
                        beat_r     <= beat_nxt_s;
                        m_tdata_r  <= pair_s;
                        m_tlast_r  <= (beat_nxt_s == LAST_BEAT);
                        m_tvalid_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                STREAM: begin
                    if (capture_s || advance_s) begin
                        beat_r     <= beat_nxt_s;
                        m_tdata_r  <= pair_s;
                        m_tlast_r  <= (beat_nxt_s == LAST_BEAT);
                        m_tvalid_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else if (last_hs_s) begin
                        state_r    <= IDLE;
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    m_tvalid_r <= 1'b0;
                    m_tlast_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign m_tdata      = m_tdata_r;
    assign m_tvalid     = m_tvalid_r;
    assign m_tlast      = m_tlast_r;
    assign busy         = busy_r;
    assign frame_cnt    = frame_cnt_r;
    assign overflow_cnt = overflow_cnt_r;

endmodule

// File: tb/tb_ad4003_frame_streamer.sv
// tb_ad4003_frame_streamer
// Self-checking bench: table of single-frame vectors plus hand-written
// sequences for overflow, back-to-back capture, enable drop and reset.
// Expected beats are queued when a frame is triggered and popped whenever
// the DUT presents a beat with m_tready high.
module tb_ad4003_frame_streamer;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         reader_en_sync;
    logic [863:0] adc_data;
    logic [63:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         busy;
    logic [15:0]  frame_cnt;
    logic [15:0]  overflow_cnt;

    ad4003_frame_streamer dut (
        .adc_read_clk   (clk),
        .rst            (rst),
        .enable         (enable),
        .reader_en_sync (reader_en_sync),
        .adc_data       (adc_data),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .overflow_cnt   (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [17:0] base;
        logic [17:0] step;
        int          rdy_mode;
        logic [63:0] exp_beat0;
    } vec_t;

    beat_t       exp_q[$];
    vec_t        vecs[4];
    logic [17:0] smp[48];
    int          errors;
    int          checks;
    int          rdy_mode;
    int          cyc_cnt;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] t, input int ch,
                                             input logic [17:0] s);
        logic [5:0] c;
        c = 6'(ch);
        return {t, c, s};
    endfunction

    task automatic set_data(input logic [17:0] base, input logic [17:0] step);
        for (int k = 0; k < 48; k++) begin
            smp[k] = base + step * 18'(k);
            adc_data[18*k +: 18] = smp[k];
        end
    endtask

    task automatic push_frame(input logic [7:0] tag, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {exp_word(tag, 2*i+1, smp[2*i+1]), exp_word(tag, 2*i, smp[2*i])};
            b.last = (i == 23);
            exp_q.push_back(b);
        end
    endtask

    // Observe outputs at the falling edge: stall stability and beat order.
    task automatic mon();
        beat_t b;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk(m_tvalid && (m_tdata == prev_data) && (m_tlast == prev_last),
                    "stall_hold", {m_tdata[62:0], m_tvalid}, {prev_data[62:0], 1'b1});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", m_tdata, 64'h0);
                end else begin
                    b = exp_q.pop_front();
                    chk(m_tdata == b.data, "beat_data", m_tdata, b.data);
                    chk(m_tlast == b.last, "beat_last", 64'(m_tlast), 64'(b.last));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_cnt++;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc_cnt % 3 == 0);
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
        @(negedge clk);
        mon();
    endtask

    // Rising edge samples high, next edge samples low: that edge captures.
    task automatic pulse();
        reader_en_sync = 1'b1;
        cycle();
        reader_en_sync = 1'b0;
        cycle();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < bound) begin
            cycle();
            n++;
        end
        chk(exp_q.size() == 0 && !m_tvalid, "drain", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc_cnt = 0;
        rdy_mode = 0;
        prev_stall = 1'b0;
        prev_data = 64'h0;
        prev_last = 1'b0;
        rst = 1'b1;
        enable = 1'b1;
        reader_en_sync = 1'b0;
        m_tready = 1'b0;
        adc_data = '0;

        vecs[0] = '{18'h00100, 18'h00001, 0, 64'h00040101_00000100};
        vecs[1] = '{18'h3FFFF, 18'h00000, 1, 64'h0107FFFF_0103FFFF};
        vecs[2] = '{18'h2AAAA, 18'h00003, 2, 64'h0206AAAD_0202AAAA};
        vecs[3] = '{18'h00000, 18'h01111, 0, 64'h03041111_03000000};

        repeat (3) cycle();
        chk(!m_tvalid && !m_tlast && !busy && m_tdata == 64'h0, "reset_outputs",
            {m_tdata[60:0], m_tvalid, m_tlast, busy}, 64'h0);
        chk(frame_cnt == 16'h0 && overflow_cnt == 16'h0, "reset_counters",
            {32'h0, frame_cnt, overflow_cnt}, 64'h0);
        rst = 1'b0;
        cycle();

        // Table-driven single frames under different ready patterns.
        for (int i = 0; i < 4; i++) begin
            rdy_mode = vecs[i].rdy_mode;
            set_data(vecs[i].base, vecs[i].step);
            push_frame(8'(i), 24);
            pulse();
            chk(m_tvalid && busy, "valid_latency", {62'h0, m_tvalid, busy}, 64'h3);
            chk(m_tdata == vecs[i].exp_beat0, "beat0", m_tdata, vecs[i].exp_beat0);
            drain(400);
            chk(frame_cnt == 16'(i + 1), "frame_cnt", 64'(frame_cnt), 64'(i + 1));
            chk(overflow_cnt == 16'h0, "no_overflow", 64'(overflow_cnt), 64'h0);
        end

        // Overflow: stalled stream while two more frames end.
        rst = 1'b1;
        #1;
        chk(!m_tvalid && frame_cnt == 16'h0, "rst_clear", {frame_cnt, 47'h0, m_tvalid}, 64'h0);
        cycle();
        rst = 1'b0;
        cycle();
        rdy_mode = 3;
        set_data(18'h00500, 18'h00001);
        push_frame(8'h00, 24);
        pulse();
        set_data(18'h03000, 18'h00007);
        pulse();
        repeat (20) cycle();
        set_data(18'h01234, 18'h00011);
        pulse();
        repeat (70) cycle();
        chk(overflow_cnt == 16'd2, "overflow_cnt", 64'(overflow_cnt), 64'd2);
        chk(frame_cnt == 16'd1, "ovf_frame_cnt", 64'(frame_cnt), 64'd1);
        chk(m_tvalid && m_tdata == 64'h00040501_00000500, "ovf_snapshot",
            m_tdata, 64'h00040501_00000500);
        rdy_mode = 0;
        drain(100);
        set_data(18'h00777, 18'h00002);
        push_frame(8'h01, 24);
        pulse();
        chk(m_tdata[31:24] == 8'h01, "tag_after_ovf", 64'(m_tdata[31:24]), 64'h1);
        drain(100);
        chk(frame_cnt == 16'd2, "frame_cnt_2", 64'(frame_cnt), 64'd2);

        // Frame end coincides with the last-beat handshake.
        set_data(18'h01234, 18'h00005);
        push_frame(8'h02, 24);
        pulse();
        repeat (22) cycle();
        set_data(18'h02222, 18'h00009);
        push_frame(8'h03, 24);
        pulse();
        chk(m_tvalid && !m_tlast && m_tdata[31:18] == {8'h03, 6'd0}, "b2b_beat0",
            {50'h0, m_tdata[31:18]}, {50'h0, 8'h03, 6'd0});
        chk(overflow_cnt == 16'd2, "b2b_no_ovf", 64'(overflow_cnt), 64'd2);
        chk(frame_cnt == 16'd4, "b2b_frame_cnt", 64'(frame_cnt), 64'd4);
        drain(100);

        // Enable dropped mid-stream: frame completes, later frames ignored.
        set_data(18'h00F0F, 18'h00003);
        push_frame(8'h04, 24);
        pulse();
        repeat (10) cycle();
        enable = 1'b0;
        drain(100);
        chk(frame_cnt == 16'd5, "en_frame_cnt", 64'(frame_cnt), 64'd5);
        pulse();
        repeat (10) cycle();
        chk(!m_tvalid && !busy, "en_idle", {62'h0, m_tvalid, busy}, 64'h0);
        chk(frame_cnt == 16'd5 && overflow_cnt == 16'd2, "en_ignored",
            {32'h0, frame_cnt, overflow_cnt}, {32'h0, 16'd5, 16'd2});

        // Reset while beat 5 is presented.
        enable = 1'b1;
        set_data(18'h01357, 18'h00001);
        push_frame(8'h05, 6);
        pulse();
        repeat (5) cycle();
        rst = 1'b1;
        #1;
        chk(!m_tvalid && !busy && !m_tlast, "rst_mid_valid",
            {61'h0, m_tvalid, busy, m_tlast}, 64'h0);
        chk(frame_cnt == 16'h0 && overflow_cnt == 16'h0, "rst_mid_counters",
            {32'h0, frame_cnt, overflow_cnt}, 64'h0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (30) cycle();
        chk(exp_q.size() == 0 && !m_tvalid, "rst_no_tail", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
